// File: rtl/bit_dcpt_pkg.sv
// -----------------------------------------------------------------------------
// bit_dcpt_pkg : shared constants and state encoding for the bit_dcpt counter
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

package bit_dcpt_pkg;

   localparam int DEFAULT_WIDTH = 3;

   typedef enum logic {
      EMPTY = 1'b0,
      RUN   = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/bit_dcpt_dec.sv
// -----------------------------------------------------------------------------
// bit_dec : combinational WIDTH-bit decrementer built from a half-subtractor chain
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module bit_dec
   import bit_dcpt_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   logic [WIDTH:0] w_b;

   // Subtracting one: the borrow chain is seeded with 1 at the LSB.
   assign w_b[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_hs
      assign diff[i]  = a[i] ^ w_b[i];
      assign w_b[i+1] = ~a[i] & w_b[i];
   end

   assign borrow = w_b[WIDTH];

endmodule

`default_nettype wire

// File: rtl/bit_dcpt.sv
// -----------------------------------------------------------------------------
// bit_dcpt : loadable down-counter with terminal-count pulse and optional reload
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module bit_dcpt
   import bit_dcpt_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int RELOAD = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             activate,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cpt,
   output logic             zero,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cpt_q, cpt_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] dec_diff;
   logic             dec_borrow;

   bit_dec #(.WIDTH(WIDTH)) u_dec (
      .a      (cpt_q),
      .diff   (dec_diff),
      .borrow (dec_borrow)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= EMPTY;
         cpt_q    <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cpt_q    <= cpt_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cpt_d    = cpt_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (load) begin
         cpt_d    = load_val;
         reload_d = load_val;
         state_d  = (load_val != '0) ? RUN : EMPTY;
      end else if (activate) begin
         case (state_q)
            RUN: begin
               cpt_d = dec_diff;
               if (cpt_q == WIDTH'(1)) begin
                  done_d  = 1'b1;
                  state_d = EMPTY;
               end
            end
            default: begin
               // EMPTY never decrements, so the counter cannot wrap to all-ones.
               if (RELOAD != 0 && reload_q != '0) begin
                  cpt_d   = reload_q;
                  state_d = RUN;
               end
            end
         endcase
      end
   end

   always @(posedge clk) begin
      if (!reset && !load && activate && state_q == RUN)
         assert (!dec_borrow) else $error("bit_dcpt: decrement committed with borrow");
   end

   assign cpt  = cpt_q;
   assign zero = (cpt_q == '0);
   assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_dcpt.sv
// -----------------------------------------------------------------------------
// tb_bit_dcpt : directed self-checking bench for bit_dcpt (RELOAD=0 and RELOAD=1)
// -----------------------------------------------------------------------------
`default_nettype none

module tb_bit_dcpt;

   logic       clk;
   logic       reset;
   logic       activate;
   logic       load;
   logic [2:0] load_val;
   logic [2:0] cpt0, cpt1;
   logic       zero0, zero1;
   logic       done0, done1;

   int errors = 0;
   int checks = 0;

   bit_dcpt #(.WIDTH(3), .RELOAD(0)) dut0 (
      .clk(clk), .reset(reset), .activate(activate), .load(load),
      .load_val(load_val), .cpt(cpt0), .zero(zero0), .done(done0)
   );

   bit_dcpt #(.WIDTH(3), .RELOAD(1)) dut1 (
      .clk(clk), .reset(reset), .activate(activate), .load(load),
      .load_val(load_val), .cpt(cpt1), .zero(zero1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; activate = 1'bx; load = 1'bx; load_val = 3'bxxx;
      tick(); tick();
      checks++; if (cpt0 !== 3'd0) begin errors++; $display("FAIL reset_cpt0 got=%0d exp=0", cpt0); end
      checks++; if (zero0 !== 1'b1) begin errors++; $display("FAIL reset_zero0 got=%b exp=1", zero0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done0 got=%b exp=0", done0); end
      checks++; if (cpt1 !== 3'd0) begin errors++; $display("FAIL reset_cpt1 got=%0d exp=0", cpt1); end
      reset = 1'b0; activate = 1'b0; load = 1'b0; load_val = 3'd0;
   endtask

   task automatic test_countdown;
      load_val = 3'd5; load = 1'b1;
      tick();
      checks++; if (cpt0 !== 3'd5) begin errors++; $display("FAIL cd_load got=%0d exp=5", cpt0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL cd_load_done got=%b exp=0", done0); end
      load = 1'b0; activate = 1'b1;
      for (int e = 4; e >= 0; e--) begin
         tick();
         checks++; if (cpt0 !== 3'(e)) begin errors++; $display("FAIL cd_cpt got=%0d exp=%0d", cpt0, e); end
         checks++; if (done0 !== (e == 0)) begin errors++; $display("FAIL cd_done at cpt=%0d got=%b exp=%b", e, done0, e == 0); end
         checks++; if (zero0 !== (e == 0)) begin errors++; $display("FAIL cd_zero at cpt=%0d got=%b exp=%b", e, zero0, e == 0); end
      end
   endtask

   task automatic test_no_wrap;
      activate = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (cpt0 !== 3'd0) begin errors++; $display("FAIL nowrap_cpt cyc=%0d got=%0d exp=0", i, cpt0); end
         checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL nowrap_done cyc=%0d got=%b exp=0", i, done0); end
         checks++; if (zero0 !== 1'b1) begin errors++; $display("FAIL nowrap_zero cyc=%0d got=%b exp=1", i, zero0); end
      end
      activate = 1'b0;
   endtask

   task automatic test_reload;
      logic [2:0] exp_seq [8];
      exp_seq = '{3'd2, 3'd1, 3'd0, 3'd3, 3'd2, 3'd1, 3'd0, 3'd3};
      activate = 1'b0; load_val = 3'd3; load = 1'b1;
      tick();
      checks++; if (cpt1 !== 3'd3) begin errors++; $display("FAIL rl_load got=%0d exp=3", cpt1); end
      load = 1'b0; activate = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (cpt1 !== exp_seq[i]) begin errors++; $display("FAIL rl_cpt step=%0d got=%0d exp=%0d", i, cpt1, exp_seq[i]); end
         checks++; if (done1 !== (exp_seq[i] == 3'd0)) begin errors++; $display("FAIL rl_done step=%0d got=%b exp=%b", i, done1, exp_seq[i] == 3'd0); end
      end
      activate = 1'b0;
      load_val = 3'd0; load = 1'b1;
      tick();
      load = 1'b0; activate = 1'b1;
      tick(); tick();
      checks++; if (cpt1 !== 3'd0) begin errors++; $display("FAIL rl_zero_hold got=%0d exp=0", cpt1); end
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL rl_zero_done got=%b exp=0", done1); end
      activate = 1'b0;
   endtask

   task automatic test_load_priority;
      activate = 1'b0; load_val = 3'd4; load = 1'b1;
      tick();
      checks++; if (cpt0 !== 3'd4) begin errors++; $display("FAIL lp_pre got=%0d exp=4", cpt0); end
      load_val = 3'd6; load = 1'b1; activate = 1'b1;
      tick();
      checks++; if (cpt0 !== 3'd6) begin errors++; $display("FAIL lp_cpt got=%0d exp=6", cpt0); end
      load = 1'b0; activate = 1'b0;
   endtask

   task automatic test_reset_midcount;
      load_val = 3'd2; load = 1'b1;
      tick();
      checks++; if (cpt0 !== 3'd2) begin errors++; $display("FAIL rm_pre got=%0d exp=2", cpt0); end
      reset = 1'b1; load_val = 3'd7; load = 1'b1; activate = 1'b1;
      tick();
      checks++; if (cpt0 !== 3'd0) begin errors++; $display("FAIL rm_cpt got=%0d exp=0", cpt0); end
      checks++; if (zero0 !== 1'b1) begin errors++; $display("FAIL rm_zero got=%b exp=1", zero0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rm_done got=%b exp=0", done0); end
      reset = 1'b0; load = 1'b0; activate = 1'b0;
   endtask

   task automatic test_toggle;
      logic [2:0] exp_cpt [4];
      logic       exp_done [4];
      exp_cpt  = '{3'd1, 3'd1, 3'd0, 3'd0};
      exp_done = '{1'b0, 1'b0, 1'b1, 1'b0};
      load_val = 3'd2; load = 1'b1;
      tick();
      checks++; if (cpt0 !== 3'd2) begin errors++; $display("FAIL tg_load got=%0d exp=2", cpt0); end
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         activate = (i % 2 == 0);
         tick();
         checks++; if (cpt0 !== exp_cpt[i]) begin errors++; $display("FAIL tg_cpt step=%0d got=%0d exp=%0d", i, cpt0, exp_cpt[i]); end
         checks++; if (done0 !== exp_done[i]) begin errors++; $display("FAIL tg_done step=%0d got=%b exp=%b", i, done0, exp_done[i]); end
      end
      activate = 1'b0;
   endtask

   task automatic test_max_range;
      load_val = 3'd7; load = 1'b1; activate = 1'b1;
      tick();
      checks++; if (cpt0 !== 3'd7) begin errors++; $display("FAIL mx_load got=%0d exp=7", cpt0); end
      load = 1'b0;
      for (int e = 6; e >= 0; e--) begin
         tick();
         checks++; if (cpt0 !== 3'(e)) begin errors++; $display("FAIL mx_cpt got=%0d exp=%0d", cpt0, e); end
         checks++; if (done0 !== (e == 0)) begin errors++; $display("FAIL mx_done at cpt=%0d got=%b exp=%b", e, done0, e == 0); end
      end
      activate = 1'b0;
   endtask

   initial begin
      reset = 1'b1; activate = 1'b0; load = 1'b0; load_val = 3'd0;
      test_reset();
      test_countdown();
      test_no_wrap();
      test_reload();
      test_load_priority();
      test_reset_midcount();
      test_toggle();
      test_max_range();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
